// File: rtl/armv7_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module   : armv7_multicycle_core
// Purpose  : Multi-cycle ARMv7-subset core (I/R/D/B formats). It has one shared
//            instruction/data memory port with a req/ack handshake, so memories
//            of any latency can be attached.
// Ports    : Clock, Reset (sync, active-high), Halt (stop at the next
//            instruction boundary)
//            mem_req/mem_we/mem_addr/mem_wdata -> memory request
//            mem_rdata/mem_ack                 <- memory response
//            pc, instr, state, flags {N,Z,C,V}, retired -> debug/observation
// Revision : 1.0 - initial multi-cycle release
// ============================================================================
module armv7_multicycle_core #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Halt,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [31:0]           instr,
    output logic [2:0]            state,
    output logic [3:0]            flags,
    output logic                  retired
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        HALTED = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_instr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_op_a;
    logic [31:0]           r_op_b;
    logic [3:0]            r_flags;
    logic                  r_cond_ok;
    logic [31:0]           r_regs [16];

    // Instruction fields
    logic [3:0] w_cond, w_opcode, w_rn, w_rd;
    logic [2:0] w_itype;
    logic       w_s, w_u, w_l;
    logic       w_is_i, w_is_r, w_is_d, w_is_b;

    assign w_cond   = r_instr[31:28];
    assign w_itype  = r_instr[27:25];
    assign w_opcode = r_instr[24:21];
    assign w_u      = r_instr[23];
    assign w_s      = r_instr[20];
    assign w_l      = r_instr[20];
    assign w_rn     = r_instr[19:16];
    assign w_rd     = r_instr[15:12];
    assign w_is_i   = (w_itype == 3'b001);
    assign w_is_r   = (w_itype == 3'b000);
    assign w_is_d   = (w_itype == 3'b010);
    assign w_is_b   = (w_itype == 3'b101);

    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] t;
        t = {x, x} >> n;
        return t[31:0];
    endfunction

    // Groups of two conditions share a base test; the low cond bit inverts it.
    // Group 7 has base 1, so AL passes and 1111 never does.
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic base;
        case (c[3:1])
            3'd0:    base = f[2];
            3'd1:    base = f[1];
            3'd2:    base = f[3];
            3'd3:    base = f[0];
            3'd4:    base = f[1] & ~f[2];
            3'd5:    base = (f[3] == f[0]);
            3'd6:    base = ~f[2] & (f[3] == f[0]);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    // Operand 2 generation, used in DECODE
    logic [31:0] w_rm, w_shifted, w_imm_rot;
    logic [4:0]  w_shamt;

    assign w_shamt   = r_instr[11:7];
    assign w_imm_rot = ror32({{24{r_instr[7]}}, r_instr[7:0]}, {r_instr[11:8], 1'b0});

    always_comb begin
        w_rm = r_regs[r_instr[3:0]];
        case (r_instr[6:5])
            2'b00:   w_shifted = w_rm << w_shamt;
            2'b01:   w_shifted = w_rm >> w_shamt;
            2'b10:   w_shifted = $signed(w_rm) >>> w_shamt;
            default: w_shifted = ror32(w_rm, w_shamt);
        endcase
    end

    // ALU. All arithmetic ops share one 33-bit adder. Subtracts use x + ~y + cin,
    // so bit 32 is directly the ARM not-borrow carry.
    logic [31:0] w_add_x, w_add_y, w_logic_res, w_alu_res;
    logic        w_add_cin, w_arith, w_alu_v, w_rd_we;
    logic [32:0] w_sum;
    logic [3:0]  w_alu_flags;

    always_comb begin
        w_add_x     = r_op_a;
        w_add_y     = r_op_b;
        w_add_cin   = 1'b0;
        w_arith     = 1'b1;
        w_logic_res = 32'd0;
        case (w_opcode)
            4'b0010, 4'b1010: begin w_add_y = ~r_op_b; w_add_cin = 1'b1; end
            4'b0011: begin w_add_x = r_op_b; w_add_y = ~r_op_a; w_add_cin = 1'b1; end
            4'b0100, 4'b1011: ;
            4'b0101: w_add_cin = r_flags[1];
            4'b0110: begin w_add_y = ~r_op_b; w_add_cin = r_flags[1]; end
            4'b0111: begin w_add_x = r_op_b; w_add_y = ~r_op_a; w_add_cin = r_flags[1]; end
            default: w_arith = 1'b0;
        endcase
        case (w_opcode)
            4'b0000, 4'b1000: w_logic_res = r_op_a & r_op_b;
            4'b0001, 4'b1001: w_logic_res = r_op_a ^ r_op_b;
            4'b1100:          w_logic_res = r_op_a | r_op_b;
            4'b1101:          w_logic_res = r_op_b;
            4'b1110:          w_logic_res = r_op_a & ~r_op_b;
            4'b1111:          w_logic_res = ~r_op_b;
            default:          w_logic_res = 32'd0;
        endcase
    end

    assign w_sum       = {1'b0, w_add_x} + {1'b0, w_add_y} + {32'd0, w_add_cin};
    assign w_alu_res   = w_arith ? w_sum[31:0] : w_logic_res;
    assign w_alu_v     = (w_add_x[31] == w_add_y[31]) & (w_sum[31] != w_add_x[31]);
    assign w_alu_flags = {w_alu_res[31], (w_alu_res == 32'd0),
                          w_arith ? w_sum[32] : r_flags[1],
                          w_arith ? w_alu_v   : r_flags[0]};
    assign w_rd_we     = ~w_opcode[3] | w_opcode[2];

    // Address arithmetic wraps naturally at ADDR_WIDTH bits
    logic [ADDR_WIDTH-1:0] w_pc_plus4, w_br_target, w_d_addr;

    assign w_pc_plus4  = r_pc + ADDR_WIDTH'(4);
    assign w_br_target = r_pc + ADDR_WIDTH'({r_instr[7:0], 2'b00});
    assign w_d_addr    = w_u ? (r_op_a[ADDR_WIDTH-1:0] + ADDR_WIDTH'(r_instr[9:0]))
                             : (r_op_a[ADDR_WIDTH-1:0] - ADDR_WIDTH'(r_instr[9:0]));

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) r_state <= FETCH;
        else       r_state <= w_next_state;
    end

    // Next state and memory-port outputs (combinational from registered state)
    always_comb begin
        w_next_state = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        retired      = 1'b0;
        case (r_state)
            FETCH: begin
                mem_req  = 1'b1;
                mem_addr = r_pc;
                if (mem_ack) w_next_state = DECODE;
            end
            DECODE: w_next_state = EXEC;
            EXEC: begin
                if (w_is_d & r_cond_ok) begin
                    w_next_state = MEM;
                end else begin
                    retired      = 1'b1;
                    w_next_state = Halt ? HALTED : FETCH;
                end
            end
            MEM: begin
                mem_req  = 1'b1;
                mem_we   = ~w_l;
                mem_addr = r_addr;
                if (mem_ack) begin
                    retired      = 1'b1;
                    w_next_state = Halt ? HALTED : FETCH;
                end
            end
            HALTED: if (!Halt) w_next_state = FETCH;
            default: w_next_state = FETCH;
        endcase
        // A request is dropped outright while Reset is high
        if (Reset) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            retired = 1'b0;
        end
    end

    // Datapath
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_pc      <= '0;
            r_addr    <= '0;
            r_instr   <= 32'd0;
            r_wdata   <= 32'd0;
            r_op_a    <= 32'd0;
            r_op_b    <= 32'd0;
            r_flags   <= 4'd0;
            r_cond_ok <= 1'b0;
            for (int i = 0; i < 16; i++) r_regs[i] <= 32'd0;
        end else begin
            case (r_state)
                FETCH: if (mem_ack) r_instr <= mem_rdata;
                DECODE: begin
                    r_op_a    <= r_regs[w_rn];
                    r_op_b    <= w_is_i ? w_imm_rot : w_shifted;
                    r_cond_ok <= cond_pass(w_cond, r_flags);
                end
                EXEC: begin
                    if (w_is_d & r_cond_ok) begin
                        r_addr  <= w_d_addr;
                        r_wdata <= r_regs[w_rd];
                    end else begin
                        r_pc <= (r_cond_ok & w_is_b) ? w_br_target : w_pc_plus4;
                        if (r_cond_ok & (w_is_i | w_is_r)) begin
                            if (w_rd_we) r_regs[w_rd] <= w_alu_res;
                            if (w_s)     r_flags      <= w_alu_flags;
                        end
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        if (w_l) r_regs[w_rd] <= mem_rdata;
                        r_pc <= w_pc_plus4;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc        = r_pc;
    assign instr     = r_instr;
    assign state     = r_state;
    assign flags     = r_flags;
    assign mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_armv7_multicycle_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_armv7_multicycle_core
// Purpose  : Directed, self-checking bench for armv7_multicycle_core. It drives
//            one 10-bit-address core and one 6-bit-address core (PC wrap).
// Revision : 1.0 - initial
// ============================================================================
module tb_armv7_multicycle_core;

    localparam logic [3:0]  c_AL  = 4'hE;
    localparam logic [3:0]  c_EQ  = 4'h0;
    localparam logic [3:0]  c_NE  = 4'h1;
    localparam logic [31:0] c_NOP = {4'hE, 3'b011, 25'd0};

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic        Reset = 1'b1;
    logic        Halt  = 1'b0;
    logic        mem_req, mem_we, mem_ack, retired;
    logic [9:0]  mem_addr, pc;
    logic [31:0] mem_wdata, mem_rdata, instr;
    logic [2:0]  state;
    logic [3:0]  flags;

    logic        mem_req6, mem_we6, mem_ack6, retired6;
    logic [5:0]  mem_addr6, pc6;
    logic [31:0] mem_wdata6, mem_rdata6, instr6;
    logic [2:0]  state6;
    logic [3:0]  flags6;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem  [256];
    logic [31:0] mem6 [16];
    int          lat  = 0;
    int          wcnt = 0;

    bit         mon_en    = 1'b0;
    bit         prev_wait = 1'b0;
    bit         prev_we   = 1'b0;
    logic [9:0] prev_addr = '0;
    int         we_cycles = 0;
    int         we_bad    = 0;

    armv7_multicycle_core #(.ADDR_WIDTH(10)) dut (
        .Clock(Clock), .Reset(Reset), .Halt(Halt),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .pc(pc), .instr(instr), .state(state), .flags(flags), .retired(retired)
    );

    armv7_multicycle_core #(.ADDR_WIDTH(6)) dut6 (
        .Clock(Clock), .Reset(Reset), .Halt(1'b0),
        .mem_req(mem_req6), .mem_we(mem_we6), .mem_addr(mem_addr6),
        .mem_wdata(mem_wdata6), .mem_rdata(mem_rdata6), .mem_ack(mem_ack6),
        .pc(pc6), .instr(instr6), .state(state6), .flags(flags6), .retired(retired6)
    );

    // Memory with programmable latency: ack after 'lat' wait cycles
    assign mem_ack    = mem_req && (wcnt == lat);
    assign mem_rdata  = mem[mem_addr[9:2]];
    assign mem_ack6   = mem_req6;
    assign mem_rdata6 = mem6[mem_addr6[5:2]];

    always @(posedge Clock) wcnt <= (!mem_req || mem_ack) ? 0 : wcnt + 1;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Writes commit mid-cycle; request signals are stable from the edge to the
    // next edge. The monitor checks that requests in a wait stay unchanged.
    always @(negedge Clock) begin
        if (mem_req && mem_we && mem_ack) mem[mem_addr[9:2]] = mem_wdata;
        if (mon_en) begin
            if (prev_wait && !Reset)
                check_value("req_stable", {20'd0, mem_req, mem_we, mem_addr},
                            {20'd0, 1'b1, prev_we, prev_addr});
            if (mem_req && mem_we) begin
                we_cycles++;
                if (mem_addr != 10'h040) we_bad++;
            end
            prev_wait = mem_req && !mem_ack;
            prev_we   = mem_we;
            prev_addr = mem_addr;
        end else begin
            prev_wait = 1'b0;
        end
    end

    function automatic logic [31:0] enc_i(input logic [3:0] c, input logic [3:0] op, input logic s,
                                          input logic [3:0] rn, input logic [3:0] rd,
                                          input logic [3:0] rot, input logic [7:0] imm);
        return {c, 3'b001, op, s, rn, rd, rot, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [3:0] c, input logic [3:0] op, input logic s,
                                          input logic [3:0] rn, input logic [3:0] rd,
                                          input logic [4:0] sha, input logic [1:0] sht,
                                          input logic [3:0] rm);
        return {c, 3'b000, op, s, rn, rd, sha, sht, 1'b0, rm};
    endfunction

    function automatic logic [31:0] enc_d(input logic [3:0] c, input logic u, input logic l,
                                          input logic [3:0] rn, input logic [3:0] rd,
                                          input logic [9:0] imm);
        return {c, 3'b010, 1'b0, u, 2'b00, l, rn, rd, 2'b00, imm};
    endfunction

    function automatic logic [31:0] enc_b(input logic [3:0] c, input logic [7:0] imm);
        return {c, 3'b101, 17'd0, imm};
    endfunction

    task automatic step();
        @(negedge Clock);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = c_NOP;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        #1;
    endtask

    // Advance until n retire pulses are seen; reports the cycles consumed
    task automatic run_retire(input bit sel6, input int n, input int budget, output int cycles);
        int cnt;
        cnt    = 0;
        cycles = 0;
        while (cnt < n && cycles < budget) begin
            if (sel6 ? retired6 : retired) cnt++;
            step();
            cycles++;
        end
        if (cnt < n) check_value("retire_timeout", cnt, n);
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        int k;
        k = 0;
        while (state != s && k < 60) begin
            step();
            k++;
        end
        check_value(tag, state, s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;

        for (int i = 0; i < 15; i++) mem6[i] = c_NOP;
        mem6[15] = enc_b(c_AL, 8'd2);

        // ---- Reset values, then zero-wait MOV R1,#5 ; ADDS R2,R1,R1 ----
        clear_mem();
        mem[0] = enc_i(c_AL, 4'b1101, 1'b0, 4'd0, 4'd1, 4'd0, 8'd5);
        mem[1] = enc_r(c_AL, 4'b0100, 1'b1, 4'd1, 4'd2, 5'd0, 2'b00, 4'd1);
        lat = 0;
        step();
        step();
        check_value("rst_state",   state,   3'd0);
        check_value("rst_pc",      pc,      10'd0);
        check_value("rst_instr",   instr,   32'd0);
        check_value("rst_flags",   flags,   4'd0);
        check_value("rst_retired", retired, 1'b0);
        check_value("rst_req",     mem_req, 1'b0);
        Reset = 1'b0;
        #1;
        check_value("t1_first_fetch", {mem_req, mem_addr}, {1'b1, 10'd0});
        run_retire(1'b0, 2, 50, cyc);
        check_value("t1_cycles", cyc, 6);
        check_value("t1_r2", dut.r_regs[2], 32'd10);
        check_value("t1_flags", flags, 4'b0000);
        check_value("t1_pc", pc, 10'd8);

        // ---- 3-cycle latency: LDR R2 ; STR R2,[R0,#0x40] ; LDR R3,[R0,#0x40] ----
        clear_mem();
        mem[0]    = enc_d(c_AL, 1'b1, 1'b1, 4'd0, 4'd2, 10'h080);
        mem[1]    = enc_d(c_AL, 1'b1, 1'b0, 4'd0, 4'd2, 10'h040);
        mem[2]    = enc_d(c_AL, 1'b1, 1'b1, 4'd0, 4'd3, 10'h040);
        mem[8'h20] = 32'hDEADBEEF;
        mem[8'h10] = 32'd0;
        lat = 3;
        do_reset();
        we_cycles = 0;
        we_bad    = 0;
        mon_en    = 1'b1;
        run_retire(1'b0, 3, 100, cyc);
        mon_en    = 1'b0;
        check_value("t2_cycles", cyc, 30);
        check_value("t2_r3", dut.r_regs[3], 32'hDEADBEEF);
        check_value("t2_mem", mem[8'h10], 32'hDEADBEEF);
        check_value("t2_we_cycles", we_cycles, 4);
        check_value("t2_we_bad", we_bad, 0);
        check_value("t2_pc", pc, 10'd12);

        // ---- SUBS then BEQ (taken) then ANDS keeps C ----
        clear_mem();
        mem[0] = enc_i(c_AL, 4'b1101, 1'b0, 4'd0, 4'd1, 4'd0, 8'd5);
        mem[1] = enc_r(c_AL, 4'b0010, 1'b1, 4'd1, 4'd4, 5'd0, 2'b00, 4'd1);
        mem[2] = enc_b(c_EQ, 8'd4);
        mem[3] = enc_i(c_AL, 4'b1101, 1'b0, 4'd0, 4'd12, 4'd0, 8'd1);
        mem[6] = enc_r(c_AL, 4'b0000, 1'b1, 4'd1, 4'd9, 5'd0, 2'b00, 4'd1);
        lat = 0;
        do_reset();
        run_retire(1'b0, 3, 50, cyc);
        check_value("t3_cycles", cyc, 9);
        check_value("t3_beq_pc", pc, 10'd24);
        check_value("t3_flags", flags, 4'b0110);
        check_value("t3_r4", dut.r_regs[4], 32'd0);
        run_retire(1'b0, 1, 20, cyc);
        check_value("t3_ands_flags", flags, 4'b0010);
        check_value("t3_r9", dut.r_regs[9], 32'd5);
        check_value("t3_r12_skipped", dut.r_regs[12], 32'd0);

        // ---- Same with BNE (not taken) ----
        mem[2] = enc_b(c_NE, 8'd4);
        do_reset();
        run_retire(1'b0, 3, 50, cyc);
        check_value("t3n_cycles", cyc, 9);
        check_value("t3n_pc", pc, 10'd12);
        run_retire(1'b0, 1, 20, cyc);
        check_value("t3n_r12", dut.r_regs[12], 32'd1);

        // ---- Overflow, shifts, rotated and sign-extended immediates ----
        clear_mem();
        mem[0] = enc_i(c_AL, 4'b1101, 1'b0, 4'd0, 4'd5, 4'd1, 8'h02);
        mem[1] = enc_r(c_AL, 4'b1101, 1'b0, 4'd0, 4'd11, 5'd4, 2'b10, 4'd5);
        mem[2] = enc_r(c_AL, 4'b1101, 1'b0, 4'd0, 4'd10, 5'd31, 2'b01, 4'd5);
        mem[3] = enc_i(c_AL, 4'b1111, 1'b0, 4'd0, 4'd5, 4'd1, 8'h02);
        mem[4] = enc_i(c_AL, 4'b1101, 1'b0, 4'd0, 4'd6, 4'd0, 8'h01);
        mem[5] = enc_r(c_AL, 4'b0100, 1'b1, 4'd5, 4'd7, 5'd0, 2'b00, 4'd6);
        mem[6] = enc_r(c_AL, 4'b0000, 1'b1, 4'd5, 4'd8, 5'd0, 2'b00, 4'd6);
        mem[7] = enc_i(c_AL, 4'b1101, 1'b0, 4'd0, 4'd13, 4'd0, 8'hF0);
        do_reset();
        run_retire(1'b0, 6, 60, cyc);
        check_value("t4_r11_asr", dut.r_regs[11], 32'hF8000000);
        check_value("t4_r10_lsr", dut.r_regs[10], 32'd1);
        check_value("t4_r5_mvn", dut.r_regs[5], 32'h7FFFFFFF);
        check_value("t4_r7", dut.r_regs[7], 32'h80000000);
        check_value("t4_adds_flags", flags, 4'b1001);
        run_retire(1'b0, 1, 20, cyc);
        check_value("t4_ands_flags", flags, 4'b0001);
        check_value("t4_r8", dut.r_regs[8], 32'd1);
        run_retire(1'b0, 1, 20, cyc);
        check_value("t4_r13_sext", dut.r_regs[13], 32'hFFFFFFF0);

        // ---- Halt during the MEM wait of an LDR ----
        clear_mem();
        mem[0]     = enc_d(c_AL, 1'b1, 1'b1, 4'd0, 4'd1, 10'h080);
        mem[8'h20] = 32'h12345678;
        lat = 3;
        do_reset();
        wait_state(3'd3, "t5_reach_mem");
        Halt = 1'b1;
        run_retire(1'b0, 1, 20, cyc);
        check_value("t5_state", state, 3'd4);
        check_value("t5_req", mem_req, 1'b0);
        check_value("t5_r1", dut.r_regs[1], 32'h12345678);
        check_value("t5_pc", pc, 10'd4);
        step();
        step();
        check_value("t5_hold", {29'd0, state}, 32'd4);
        Halt = 1'b0;
        step();
        check_value("t5_resume", {mem_req, state, mem_addr}, {1'b1, 3'd0, 10'd4});

        // ---- Reset while a store is waiting in MEM ----
        clear_mem();
        mem[0]     = enc_i(c_AL, 4'b1101, 1'b0, 4'd0, 4'd1, 4'd0, 8'd7);
        mem[1]     = enc_d(c_AL, 1'b1, 1'b0, 4'd0, 4'd1, 10'h040);
        mem[8'h10] = 32'd0;
        do_reset();
        wait_state(3'd3, "t6_reach_mem");
        check_value("t6_store_req", {mem_req, mem_we}, 2'b11);
        Reset = 1'b1;
        #1;
        check_value("t6_req_dropped", mem_req, 1'b0);
        step();
        check_value("t6_state", state, 3'd0);
        check_value("t6_pc", pc, 10'd0);
        check_value("t6_r1", dut.r_regs[1], 32'd0);
        Reset = 1'b0;
        #1;
        check_value("t6_refetch", {mem_req, mem_addr}, {1'b1, 10'd0});
        check_value("t6_no_write", mem[8'h10], 32'd0);

        // ---- ADDR_WIDTH=6: branch from 60 with imm8=2 wraps to 4 ----
        lat = 0;
        do_reset();
        run_retire(1'b1, 15, 100, cyc);
        check_value("t7_pc60", pc6, 6'd60);
        run_retire(1'b1, 1, 20, cyc);
        check_value("t7_wrap", pc6, 6'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/armv7_multicycle_core.md
# armv7_multicycle_core

Parametrised multi-cycle successor to the team's single-cycle ARMv7-subset core. It executes the same I/R/D/B instruction subset through a state machine with one shared instruction/data memory port and a req/ack handshake, so memories of any latency can be attached. Address width is configurable. It also adds Halt-at-boundary, retire pulses and an observable state for the debug display.

## Interface
- ADDR_WIDTH, 10: byte address width of PC and memory port (≥4).
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high.
- Halt  in  1  request to stop at next instruction boundary.
- mem_req  out  1  memory request; held until ack.
- mem_we  out  1  write strobe, valid with mem_req.
- mem_addr  out  ADDR_WIDTH  request address.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data, valid when mem_ack=1.
- mem_ack  in  1  completes the current request this cycle (same-cycle ack allowed).
- pc  out  ADDR_WIDTH  current PC.
- instr  out  32  latched instruction.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, HALTED=4.
- flags  out  4  {N,Z,C,V}.
- retired  out  1  one-cycle pulse per completed instruction.

## Operation
- Registers: 16x32 file, R15 is an ordinary register (not PC), cleared on Reset.
- The instruction fields are:
  - cond [31:28]: standard ARM conditions on NZCV. AL=1110; 1111 never executes.
  - type [27:25]: 001 I, 000 R, 010 D, 101 B. Any other value is a NOP.
  - opcode [24:21], S [20], Rn [19:16], Rd [15:12].
- I operand: the sign-extended imm8 [7:0] is rotated right by 2*[11:8].
- R operand: Rm [3:0] is shifted by [11:7] using type [6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR).
- ALU opcodes: AND, EOR, SUB, RSB, ADD, ADC, SBC, RSC, TST, TEQ, CMP, CMN, ORR, MOV, BIC, MVN (0000..1111).
  - Rd is written when ~op[3] | op[2].
  - With S=1, N and Z come from the 32-bit result.
  - Arithmetic ops set C to carry-out (not-borrow for subtracts) and V to signed overflow.
  - Logical ops leave C and V unchanged.
- D: address = Rn[ADDR_WIDTH-1:0] ± imm[9:0] zero-extended, using + when U [23]=1. The sum wraps modulo 2^ADDR_WIDTH.
  - L [20]=1 is LDR: mem_rdata is written to Rd.
  - L=0 is STR: mem_wdata = Rd.
- B: PC ← PC + {imm8[7:0],2'b00}, taken relative to the branch's own PC. The sum is truncated to ADDR_WIDTH and wraps.
- PC ← PC+4 for every other instruction, including condition-failed instructions and NOPs.
- State machine:
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. On mem_ack, latch instr and go to DECODE.
  - DECODE: read the operands and evaluate the condition. Go to EXEC.
  - EXEC, I/R/B/failed/NOP: commit Rd, flags and PC at the end of the cycle, pulse retired, and go to FETCH. Go to HALTED instead if Halt=1.
  - EXEC, D: latch the address and store data, then go to MEM.
  - MEM: mem_req=1, mem_we=~L. On mem_ack, write Rd for LDR, update PC, pulse retired, and go to FETCH (HALTED if Halt=1).
  - HALTED: no request. Go to FETCH when Halt=0.
- Halt never aborts a request in flight. mem_req, mem_we and mem_addr stay stable until ack.

## Timing
- Reset values: state=FETCH, pc=0, instr=0, flags=0, retired=0, all registers 0.
- mem_req is forced to 0 while Reset=1. The first fetch (address 0) is issued in the cycle after Reset deasserts.
- Reset mid-operation: any in-flight request is abandoned with no register, flag or memory side effects. The memory must tolerate a dropped request.
- mem_req, mem_we and mem_addr are combinational from registered state. A same-cycle ack completes a request in that cycle.
- With zero-wait ack, ALU/B instructions take 3 cycles and LDR/STR take 4. Each wait cycle adds one.
- retired asserts in the last cycle of an instruction. Its effects are visible in the following cycle.
- Halt is sampled only at the instruction boundary. When Halt drops, the next fetch is issued in the cycle after HALTED exits.

## Test plan
- Zero-wait memory, program MOV R1,#5; ADDS R2,R1,R1 → R2=10, flags=0000, 2 retired pulses in 6 cycles, pc=8.
- 3-cycle ack latency on every request, STR R2,[R0,#0x40] then LDR R3,[R0,#0x40] with R2=0xDEADBEEF → R3=0xDEADBEEF. Request signals are stable through the wait cycles and mem_we=1 only on the store.
- SUBS R4,R1,R1 (R1=5) then a BEQ with imm8=4 → Z=1, C=1, and the branch moves pc from 8 to 24. With an NE condition instead, pc goes to 12 and retired still pulses.
- ADDS of 0x7FFFFFFF+1 → N=1, V=1, C=0, Z=0. A following ANDS leaves C and V unchanged.
- Halt asserted during the MEM wait of an LDR → the load completes, state goes to 4 with no mem_req. Releasing Halt gives a fetch at pc+4.
- Reset pulsed while mem_req=1 in MEM → no memory write, state=0, pc=0, registers 0. Fetch at address 0 occurs in the next cycle. With ADDR_WIDTH=6, a branch from 60 with imm8=2 wraps pc to 4.
